// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RISC-V decode stage: control/immediate decode, bypassed register file,
// load-use hazard bubbles, flush, and the registered ID/EX pipeline output.
package id_stage_pipe_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_ctrl;
  } riscv_control_t;
endpackage

module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 5,
  parameter int NREGS = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   instr_in,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               we_in,
  input  logic [INDEX-1:0]   rd_in,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               ex_memread_in,
  input  logic [INDEX-1:0]   ex_rd_in,
  output logic               ready_out,
  output logic               valid_out,
  output logic [WIDTH-1:0]   pc_out,
  output logic [INDEX-1:0]   rs1_out,
  output logic [INDEX-1:0]   rs2_out,
  output logic [INDEX-1:0]   rd_out,
  output logic [WIDTH-1:0]   drs1_out,
  output logic [WIDTH-1:0]   drs2_out,
  output logic [WIDTH-1:0]   signimm_out,
  output riscv_control_t     ctrl_vector_out,
  output logic               illegal_out
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [INDEX-1:0] rd, rs1, rs2;
  logic [31:0]      imm32;
  logic [WIDTH-1:0] signimm, drs1, drs2;
  logic [WIDTH-1:0] regs [NREGS];
  riscv_control_t   ctrl;
  logic             hazard, illegal;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign rd     = INDEX'(instr_in[11:7]);
  assign rs1    = INDEX'(instr_in[19:15]);
  assign rs2    = INDEX'(instr_in[24:20]);

  always_comb begin
    ctrl = '0;
    case (opcode)
      7'b0110011: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = {instr_in[30], funct3};
      end
      7'b0010011: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // only srai carries funct7[5]; for other I-ALU ops that bit is immediate
        ctrl.alu_ctrl  = {(funct3 == 3'b101) & instr_in[30], funct3};
      end
      7'b0000011: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      7'b0100011: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      7'b1100011: ctrl.branch = 1'b1;
      7'b1101111: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      7'b1100111: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111:
        imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      7'b0100011:
        imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      7'b1100011:
        imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instr_in[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      default: ;
    endcase
  end

  assign signimm = WIDTH'($signed(imm32));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we_in && rd_in != '0 && 32'(rd_in) < NREGS) begin
      regs[rd_in[AW-1:0]] <= data_in;
    end
  end

  // same-cycle writeback is forwarded so decode never sees a stale value
  always_comb begin
    drs1 = '0;
    if (we_in && rd_in != '0 && rd_in == rs1) drs1 = data_in;
    else if (rs1 != '0 && 32'(rs1) < NREGS) drs1 = regs[rs1[AW-1:0]];
  end

  always_comb begin
    drs2 = '0;
    if (we_in && rd_in != '0 && rd_in == rs2) drs2 = data_in;
    else if (rs2 != '0 && 32'(rs2) < NREGS) drs2 = regs[rs2[AW-1:0]];
  end

  assign hazard    = valid_in && ex_memread_in && ex_rd_in != '0 &&
                     (ex_rd_in == rs1 || ex_rd_in == rs2);
  assign illegal   = 32'(rs1) >= NREGS || 32'(rs2) >= NREGS || 32'(rd) >= NREGS;
  assign ready_out = !stall_in && !hazard && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      valid_out       <= 1'b0;
      pc_out          <= '0;
      rs1_out         <= '0;
      rs2_out         <= '0;
      rd_out          <= '0;
      drs1_out        <= '0;
      drs2_out        <= '0;
      signimm_out     <= '0;
      ctrl_vector_out <= '0;
      illegal_out     <= 1'b0;
    end else if (!stall_in) begin
      if (hazard) begin
        valid_out       <= 1'b0;
        ctrl_vector_out <= '0;
        illegal_out     <= 1'b0;
      end else begin
        valid_out       <= valid_in;
        pc_out          <= pc_in;
        rs1_out         <= rs1;
        rs2_out         <= rs2;
        rd_out          <= rd;
        drs1_out        <= drs1;
        drs2_out        <= drs2;
        signimm_out     <= signimm;
        ctrl_vector_out <= (valid_in && !illegal) ? ctrl : '0;
        illegal_out     <= valid_in && illegal;
      end
    end
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage: field extraction, control decode, internal register file, sign-extended immediate, registered ID/EX pipeline output.
- Adds over the plain decode stage:
  - valid/ready flow control
  - load-use hazard detection with bubble insertion
  - flush
  - register-file write-through bypass
  - configurable register count (RV32I or RV32E)
- Sits between IF and EX; all outputs are registered (ID/EX register lives here).

Parameters:
- WIDTH, 32, datapath and instruction width.
- INDEX, 5, register-index width in bits.
- NREGS, 32, architectural registers: 32 (RV32I) or 16 (RV32E); must satisfy NREGS <= 2**INDEX.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- valid_in  input  1  instr_in/pc_in hold a valid instruction from IF.
- instr_in  input  WIDTH  instruction word.
- pc_in  input  WIDTH  instruction PC.
- stall_in  input  1  downstream stall; hold the ID/EX register.
- flush_in  input  1  branch/jump redirect; kill the instruction in decode.
- we_in  input  1  writeback enable.
- rd_in  input  INDEX  writeback destination.
- data_in  input  WIDTH  writeback data.
- ex_memread_in  input  1  instruction currently in EX is a load.
- ex_rd_in  input  INDEX  destination of the instruction in EX.
- ready_out  output  1  decode accepts instr_in this cycle (to IF/PC enable).
- valid_out  output  1  ID/EX register holds a valid instruction.
- pc_out  output  WIDTH  registered PC.
- rs1_out, rs2_out, rd_out  output  INDEX  registered register indices.
- drs1_out, drs2_out  output  WIDTH  registered operand data.
- signimm_out  output  WIDTH  registered immediate.
- ctrl_vector_out  output  riscv_control_t  registered control vector.
- illegal_out  output  1  registered: decoded instruction references a register >= NREGS.

Behaviour:
- Combinational decode:
  - opcode = instr_in[6:0], funct3 = [14:12], funct7 = [31:25], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - Control decode via the existing control unit; immediate via signimm.
- Register file:
  - NREGS x WIDTH; all entries cleared on rst_in.
  - Write on clk when we_in and rd_in != 0 and rd_in < NREGS.
  - Writes with rd_in >= NREGS are ignored.
  - x0 always reads 0.
- Write-through bypass: if we_in, rd_in != 0 and rd_in == rs1 (or rs2) in the same cycle, read data = data_in.
- Hazard (combinational):
  - hazard = valid_in & ex_memread_in & (ex_rd_in != 0) & (ex_rd_in == rs1 | ex_rd_in == rs2).
  - ready_out = !stall_in & !hazard & !rst_in.
- Illegal: rs1, rs2 or rd >= NREGS (RV32E only). The instruction still advances, with ctrl_vector_out forced to 0 and illegal_out = 1.
- ID/EX register update priority (per clk, highest first):
  1. rst_in: valid_out = 0, ctrl_vector_out = 0, illegal_out = 0, all data/index/pc outputs = 0.
  2. flush_in: valid_out = 0, ctrl_vector_out = 0, illegal_out = 0; data fields don't-care (load 0). Flush overrides stall_in.
  3. stall_in: hold all outputs unchanged.
  4. hazard: insert bubble (valid_out = 0, ctrl_vector_out = 0). The instruction stays at the input; IF must hold it because ready_out = 0.
  5. otherwise: load the decoded fields. valid_out = valid_in; ctrl_vector_out = decoded control when valid_in and not illegal, else 0.
- Latency: 1 cycle from instr_in to outputs.
- A register-file write and a stall in the same cycle: the write is still performed.
- Reset mid-stall clears the pipeline register; the register file is also cleared.
- Invariant: ctrl_vector_out is never non-zero while valid_out = 0.

Test Plan:
- Reset: assert rst_in for 2 cycles -> valid_out = 0, ctrl_vector_out = 0, all outputs 0, ready_out = 0 while in reset; reading x5 afterwards returns 0.
- Basic decode: write x1 = 0x0000_0005, then present `addi x2,x1,-3` (0xFFD08113), valid_in = 1 -> next cycle valid_out = 1, rs1_out = 1, rd_out = 2, drs1_out = 5, signimm_out = 0xFFFF_FFFD.
- Bypass: same cycle we_in = 1, rd_in = 3, data_in = 0xDEAD_BEEF while decoding `add x4,x3,x0` -> drs1_out = 0xDEAD_BEEF next cycle. A write to x0 with 0x1234 leaves x0 reading 0.
- Load-use: ex_memread_in = 1, ex_rd_in = 7, instr `add x8,x7,x9` -> ready_out = 0, next cycle valid_out = 0 with ctrl 0. Deassert ex_memread_in -> instruction issues the following cycle.
- Stall vs flush:
  - stall_in for 3 cycles -> outputs frozen, ready_out = 0.
  - stall_in and flush_in together -> valid_out = 0.
- RV32E: with NREGS = 16, decode `addi x17,x0,1` -> illegal_out = 1, ctrl_vector_out = 0; we_in to x20 does not alter any register.
